// File: rtl/mips_pkg.sv
// +----------------------------------------------------------------------------+
// | mips_pkg                                                                   |
// | Shared types and constants for the 5-stage MIPS core.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

  localparam int c_reg_aw = 5;

  // sll $0, $0, 0
  localparam logic [31:0] c_nop = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } hcu_state_e;

endpackage

`default_nettype wire

// File: rtl/hazard_control_unit_sat_counter.sv
// +----------------------------------------------------------------------------+
// | sat_counter                                                                |
// | Up-counter that sticks at all-ones instead of wrapping.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] c_max = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (inc && (r_count != c_max)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// +----------------------------------------------------------------------------+
// | hazard_control_unit                                                        |
// | Pipeline sequencer: load-use stalls, branch flushes, memory-wait freezes.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module hazard_control_unit
  import mips_pkg::*;
#(
  parameter int REG_AW       = c_reg_aw,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_mem_read,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              if_id_enable,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int c_fcnt_w = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [c_fcnt_w-1:0] c_flush_init = c_fcnt_w'(FLUSH_CYCLES - 1);
  localparam logic [c_fcnt_w-1:0] c_one = c_fcnt_w'(1);
  localparam logic c_multi_flush = (FLUSH_CYCLES > 1);

  hcu_state_e          r_state;
  hcu_state_e          r_saved_state;
  logic                r_pending;
  logic [c_fcnt_w-1:0] r_flush_cnt;

  hcu_state_e          w_state_nxt;
  hcu_state_e          w_saved_nxt;
  hcu_state_e          w_eval_state;
  logic                w_pending_nxt;
  logic [c_fcnt_w-1:0] w_flush_cnt_nxt;
  logic                w_load_use;
  logic                w_branch;
  logic                w_flush_apply;
  logic                w_pc_write;
  logic                w_if_id_enable;
  logic                w_if_id_flush;
  logic                w_id_ex_bubble;

  assign w_load_use = ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // A branch seen while frozen is remembered so it is applied once memory frees up.
  assign w_branch = branch_taken || r_pending;

  // Leaving HOLD resumes whatever state was interrupted.
  assign w_eval_state = (r_state == HOLD) ? r_saved_state : r_state;

  always_comb begin
    w_state_nxt     = RUN;
    w_saved_nxt     = r_saved_state;
    w_pending_nxt   = r_pending;
    w_flush_cnt_nxt = r_flush_cnt;
    w_flush_apply   = 1'b0;
    w_pc_write      = 1'b1;
    w_if_id_enable  = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_bubble  = 1'b0;

    if (mem_busy) begin
      w_pc_write     = 1'b0;
      w_if_id_enable = 1'b0;
      w_state_nxt    = HOLD;
      w_saved_nxt    = w_eval_state;
      w_pending_nxt  = r_pending || branch_taken;
    end else if (w_branch) begin
      w_if_id_flush   = 1'b1;
      w_id_ex_bubble  = 1'b1;
      w_flush_apply   = 1'b1;
      w_pending_nxt   = 1'b0;
      w_flush_cnt_nxt = c_flush_init;
      w_state_nxt     = c_multi_flush ? FLUSH : RUN;
    end else if (w_eval_state == FLUSH) begin
      // ID holds a flushed NOP here, so load-use is not evaluated.
      w_if_id_flush   = 1'b1;
      w_id_ex_bubble  = 1'b1;
      w_flush_cnt_nxt = r_flush_cnt - c_one;
      w_state_nxt     = (r_flush_cnt <= c_one) ? RUN : FLUSH;
    end else if (w_load_use) begin
      w_pc_write     = 1'b0;
      w_if_id_enable = 1'b0;
      w_id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= RUN;
      r_saved_state <= RUN;
      r_pending     <= 1'b0;
      r_flush_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_saved_state <= w_saved_nxt;
      r_pending     <= w_pending_nxt;
      r_flush_cnt   <= w_flush_cnt_nxt;
    end
  end

  // While reset is asserted the pipeline is frozen and filled with NOPs.
  assign pc_write     = reset ? w_pc_write     : 1'b0;
  assign if_id_enable = reset ? w_if_id_enable : 1'b0;
  assign if_id_flush  = reset ? w_if_id_flush  : 1'b1;
  assign id_ex_bubble = reset ? w_id_ex_bubble : 1'b1;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (~w_pc_write),
    .count (stall_cycles)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (w_flush_apply),
    .count (flush_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// +----------------------------------------------------------------------------+
// | tb_hazard_control_unit                                                     |
// | Self-checking bench for hazard_control_unit (FLUSH_CYCLES=2, CNT_W=4).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hazard_control_unit;

  localparam int c_nvec = 32;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic [4:0] ex_rt;
  logic       ex_mem_read;
  logic       branch_taken;
  logic       mem_busy;
  logic       pc_write;
  logic       if_id_enable;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic [3:0] stall_cycles;
  logic [3:0] flush_count;

  int errors = 0;
  int checks = 0;

  // {reset, rs, rt, uses_rt, ex_rt, mem_read, branch, busy} -> {pc,en,flush,bubble}, stall, flush
  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic [4:0] xrt;
    logic       mrd;
    logic       br;
    logic       busy;
    logic [3:0] outs;
    logic [3:0] st;
    logic [3:0] fc;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] outs;
    logic [3:0] st;
    logic [3:0] fc;
  } exp_t;

  vec_t vecs [c_nvec];
  exp_t sb [$];

  hazard_control_unit #(
    .REG_AW       (5),
    .FLUSH_CYCLES (2),
    .CNT_W        (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_rt        (ex_rt),
    .ex_mem_read  (ex_mem_read),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .pc_write     (pc_write),
    .if_id_enable (if_id_enable),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic [4:0] rs, logic [4:0] rt, logic uses,
                              logic [4:0] xrt, logic mrd, logic br, logic busy,
                              logic [3:0] outs, logic [3:0] st, logic [3:0] fc);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.uses = uses; v.xrt = xrt;
    v.mrd = mrd; v.br = br; v.busy = busy; v.outs = outs; v.st = st; v.fc = fc;
    return v;
  endfunction

  task automatic check4(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    check4({e.name, " outs"}, {pc_write, if_id_enable, if_id_flush, id_ex_bubble}, e.outs);
    check4({e.name, " stall"}, stall_cycles, e.st);
    check4({e.name, " flush"}, flush_count, e.fc);
  endtask

  // Drive one cycle of inputs just after the edge, check at the following falling edge.
  task automatic apply(vec_t v, string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = v.rst;
    id_rs        = v.rs;
    id_rt        = v.rt;
    id_uses_rt   = v.uses;
    ex_rt        = v.xrt;
    ex_mem_read  = v.mrd;
    branch_taken = v.br;
    mem_busy     = v.busy;
    e.name = name; e.outs = v.outs; e.st = v.st; e.fc = v.fc;
    sb.push_back(e);
    @(negedge clk);
    check_front();
  endtask

  initial begin
    int exp_st;
    int exp_fc;
    vec_t v;

    reset = 1'b0; id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0; ex_rt = 5'd3;
    ex_mem_read = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;

    //            rst rs  rt  use xrt mrd br bsy outs     st  fc
    vecs[0]  = mk(0, 1,  2,  0,  3,  0,  0, 0, 4'b0011, 0,  0);  // reset
    vecs[1]  = mk(0, 1,  2,  0,  3,  0,  0, 0, 4'b0011, 0,  0);
    vecs[2]  = mk(1, 1,  2,  0,  3,  0,  0, 0, 4'b1100, 0,  0);  // normal
    vecs[3]  = mk(1, 8,  2,  0,  8,  1,  0, 0, 4'b0001, 0,  0);  // load-use rs
    vecs[4]  = mk(1, 1,  2,  0,  3,  0,  0, 0, 4'b1100, 1,  0);
    vecs[5]  = mk(1, 0,  2,  0,  0,  1,  0, 0, 4'b1100, 1,  0);  // load to $0
    vecs[6]  = mk(1, 1,  9,  0,  9,  1,  0, 0, 4'b1100, 1,  0);  // rt not used
    vecs[7]  = mk(1, 1,  9,  1,  9,  1,  0, 0, 4'b0001, 1,  0);  // rt used
    vecs[8]  = mk(1, 1,  2,  0,  3,  0,  0, 0, 4'b1100, 2,  0);
    vecs[9]  = mk(1, 1,  2,  0,  3,  0,  1, 0, 4'b1111, 2,  0);  // branch
    vecs[10] = mk(1, 1,  2,  0,  3,  0,  0, 0, 4'b1111, 2,  1);  // 2nd flush cycle
    vecs[11] = mk(1, 1,  2,  0,  3,  0,  0, 0, 4'b1100, 2,  1);
    vecs[12] = mk(1, 8,  2,  0,  8,  1,  1, 0, 4'b1111, 2,  1);  // branch beats load-use
    vecs[13] = mk(1, 8,  2,  0,  8,  1,  0, 0, 4'b1111, 2,  2);  // load-use ignored in FLUSH
    vecs[14] = mk(1, 1,  2,  0,  3,  0,  0, 0, 4'b1100, 2,  2);
    vecs[15] = mk(1, 1,  2,  0,  3,  0,  0, 1, 4'b0000, 2,  2);  // hold
    vecs[16] = mk(1, 1,  2,  0,  3,  0,  1, 1, 4'b0000, 3,  2);  // branch while hold
    vecs[17] = mk(1, 1,  2,  0,  3,  0,  0, 1, 4'b0000, 4,  2);
    vecs[18] = mk(1, 1,  2,  0,  3,  0,  0, 0, 4'b1111, 5,  2);  // pending branch applied
    vecs[19] = mk(1, 1,  2,  0,  3,  0,  0, 0, 4'b1111, 5,  3);
    vecs[20] = mk(1, 1,  2,  0,  3,  0,  0, 0, 4'b1100, 5,  3);
    vecs[21] = mk(1, 1,  2,  0,  3,  0,  1, 0, 4'b1111, 5,  3);  // branch
    vecs[22] = mk(1, 1,  2,  0,  3,  0,  0, 1, 4'b0000, 5,  4);  // hold mid-flush
    vecs[23] = mk(1, 1,  2,  0,  3,  0,  0, 0, 4'b1111, 6,  4);  // resume flush
    vecs[24] = mk(1, 1,  2,  0,  3,  0,  0, 0, 4'b1100, 6,  4);
    vecs[25] = mk(1, 1,  2,  0,  3,  0,  1, 0, 4'b1111, 6,  4);  // branch
    vecs[26] = mk(1, 1,  2,  0,  3,  0,  1, 0, 4'b1111, 6,  5);  // restart in FLUSH
    vecs[27] = mk(1, 1,  2,  0,  3,  0,  0, 0, 4'b1111, 6,  6);
    vecs[28] = mk(1, 1,  2,  0,  3,  0,  0, 0, 4'b1100, 6,  6);
    vecs[29] = mk(1, 8,  2,  0,  8,  1,  0, 1, 4'b0000, 6,  6);  // busy beats load-use
    vecs[30] = mk(1, 8,  2,  0,  8,  1,  0, 0, 4'b0001, 7,  6);
    vecs[31] = mk(1, 1,  2,  0,  3,  0,  0, 0, 4'b1100, 8,  6);

    for (int i = 0; i < c_nvec; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Stall counter saturation under a long memory wait.
    apply(mk(0, 1, 2, 0, 3, 0, 0, 0, 4'b0011, 0, 0), "sat_reset");
    exp_st = 0;
    for (int i = 0; i < 20; i++) begin
      apply(mk(1, 1, 2, 0, 3, 0, 0, 1, 4'b0000, 4'(exp_st), 0), $sformatf("sat_st%0d", i));
      exp_st = (exp_st < 15) ? exp_st + 1 : 15;
    end

    // Flush counter saturation with a branch every cycle.
    exp_fc = 0;
    for (int i = 0; i < 20; i++) begin
      apply(mk(1, 1, 2, 0, 3, 0, 1, 0, 4'b1111, 4'(exp_st), 4'(exp_fc)), $sformatf("sat_fc%0d", i));
      exp_fc = (exp_fc < 15) ? exp_fc + 1 : 15;
    end
    apply(mk(1, 1, 2, 0, 3, 0, 0, 0, 4'b1111, 15, 15), "sat_fc_tail");

    // Asynchronous reset in the middle of a flush window.
    apply(mk(1, 1, 2, 0, 3, 0, 0, 0, 4'b1100, 15, 15), "pre_rst");
    apply(mk(1, 1, 2, 0, 3, 0, 1, 0, 4'b1111, 15, 15), "pre_rst_br");
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check4("async_rst outs", {pc_write, if_id_enable, if_id_flush, id_ex_bubble}, 4'b0011);
    check4("async_rst stall", stall_cycles, 4'd0);
    check4("async_rst flush", flush_count, 4'd0);
    v = mk(1, 1, 2, 0, 3, 0, 0, 0, 4'b1100, 0, 0);
    apply(v, "post_rst_run");
    apply(v, "post_rst_run2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
